// File: rtl/ibex_data_bus_demux.sv
// Ibex-style data bus demultiplexer: one LSU master fanned out to NUM_SLAVES
// slaves by address decode, with a single outstanding transaction, error
// responses for unmapped addresses and a response timeout.
module ibex_data_bus_demux #(
  parameter int unsigned                NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE     = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK     = {NUM_SLAVES{32'h0}},
  parameter int unsigned                TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       m_req,
  input  logic [31:0]                m_addr,
  input  logic                       m_we,
  input  logic [3:0]                 m_be,
  input  logic [31:0]                m_wdata,
  output logic                       m_gnt,
  output logic                       m_rvalid,
  output logic                       m_err,
  output logic [31:0]                m_rdata,
  output logic [NUM_SLAVES-1:0]      s_req,
  output logic [31:0]                s_addr,
  output logic                       s_we,
  output logic [3:0]                 s_be,
  output logic [31:0]                s_wdata,
  input  logic [NUM_SLAVES-1:0]      s_gnt,
  input  logic [NUM_SLAVES-1:0]      s_rvalid,
  input  logic [NUM_SLAVES-1:0]      s_err,
  input  logic [NUM_SLAVES*32-1:0]   s_rdata
);

  localparam int unsigned SelW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RSP = 2'd1,
    ERR_RSP  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [SelW-1:0]       sel_q, sel_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0] stale_q, stale_d;

  logic                  hitValid;
  logic [SelW-1:0]       hitIdx;
  logic                  canIssue;
  logic                  issueMiss;
  logic                  issueHit;
  logic                  issueGnt;
  logic [NUM_SLAVES-1:0] issueReq;
  logic                  timeoutHit;

  // Address, write enable, byte enables and write data go to every slave.
  assign s_addr  = m_addr;
  assign s_we    = m_we;
  assign s_be    = m_be;
  assign s_wdata = m_wdata;

  // Address decode; scanning downwards lets the lowest matching index win.
  always_comb begin
    hitValid = 1'b0;
    hitIdx   = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        hitValid = 1'b1;
        hitIdx   = SelW'(i);
      end
    end
  end

  // A new request may be accepted when idle or in the cycle the current response returns.
  always_comb begin
    canIssue  = rst_n && ((state_q == IDLE) || ((state_q == WAIT_RSP) && s_rvalid[sel_q]));
    issueMiss = canIssue && m_req && !hitValid;
    issueHit  = canIssue && m_req && hitValid && !stale_q[hitIdx];
    issueReq  = '0;
    if (issueHit) begin
      issueReq[hitIdx] = 1'b1;
    end
    issueGnt  = issueHit && s_gnt[hitIdx];
    timeoutHit = (TIMEOUT_CYCLES != 0) && (state_q == WAIT_RSP) && !s_rvalid[sel_q] &&
                 ((32'(cnt_q) + 32'd1) == TIMEOUT_CYCLES);
  end

  // State, selected slave, timeout counter and stale flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      stale_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
    end
  end

  // Next-state logic: response tracking, timeout, then any newly issued request.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    stale_d = stale_q & ~s_rvalid;
    unique case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      WAIT_RSP: begin
        if (s_rvalid[sel_q]) begin
          state_d = IDLE;
        end else begin
          if (32'(cnt_q) < TIMEOUT_CYCLES) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (timeoutHit) begin
            state_d        = ERR_RSP;
            stale_d[sel_q] = 1'b1;
          end
        end
      end
      ERR_RSP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (issueMiss) begin
      state_d = ERR_RSP;
    end else if (issueGnt) begin
      state_d = WAIT_RSP;
      sel_d   = hitIdx;
      cnt_d   = '0;
    end
  end

  // Outputs: request/grant from the issue logic, response steered from the selected slave.
  always_comb begin
    s_req    = issueReq;
    m_gnt    = issueMiss | issueGnt;
    m_rvalid = 1'b0;
    m_err    = 1'b0;
    m_rdata  = '0;
    unique case (state_q)
      WAIT_RSP: begin
        m_rvalid = s_rvalid[sel_q];
        m_err    = s_err[sel_q];
        m_rdata  = s_rdata[{sel_q, 5'b00000} +: 32];
      end
      ERR_RSP: begin
        m_rvalid = 1'b1;
        m_err    = 1'b1;
      end
      default: begin
        m_rvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ibex_data_bus_demux.sv
// Self-checking bench for ibex_data_bus_demux: directed scenarios plus
// randomized transactions checked against a transaction-level model.
module tb_ibex_data_bus_demux;

  localparam int NS = 4;
  localparam int TO = 8;
  // slave0 0x20xx, slave1 0x1xxx, slave2 0x2xxx (shadowed by slave0 on 0x20xx), slave3 0x3xxx
  localparam logic [NS*32-1:0] BASE = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_2000};
  localparam logic [NS*32-1:0] MASK = {32'h0000_F000, 32'h0000_F000, 32'h0000_F000, 32'h0000_FF00};

  logic              clk = 1'b0;
  logic              rst_n;
  logic              m_req;
  logic [31:0]       m_addr;
  logic              m_we;
  logic [3:0]        m_be;
  logic [31:0]       m_wdata;
  logic              m_gnt;
  logic              m_rvalid;
  logic              m_err;
  logic [31:0]       m_rdata;
  logic [NS-1:0]     s_req;
  logic [31:0]       s_addr;
  logic              s_we;
  logic [3:0]        s_be;
  logic [31:0]       s_wdata;
  logic [NS-1:0]     s_gnt;
  logic [NS-1:0]     s_rvalid;
  logic [NS-1:0]     s_err;
  logic [NS*32-1:0]  s_rdata;

  int                checks = 0;
  int                errors = 0;
  logic [NS-1:0]     staleRef = '0;
  logic [NS-1:0]     lastRv = '0;

  ibex_data_bus_demux #(
    .NUM_SLAVES     (NS),
    .SLAVE_BASE     (BASE),
    .SLAVE_MASK     (MASK),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_req    (m_req),
    .m_addr   (m_addr),
    .m_we     (m_we),
    .m_be     (m_be),
    .m_wdata  (m_wdata),
    .m_gnt    (m_gnt),
    .m_rvalid (m_rvalid),
    .m_err    (m_err),
    .m_rdata  (m_rdata),
    .s_req    (s_req),
    .s_addr   (s_addr),
    .s_we     (s_we),
    .s_be     (s_be),
    .s_wdata  (s_wdata),
    .s_gnt    (s_gnt),
    .s_rvalid (s_rvalid),
    .s_err    (s_err),
    .s_rdata  (s_rdata)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Run-away guard.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Which slave the spec's decode rule selects: first index whose masked address equals its base.
  function automatic int refDecode(input logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if ((a & MASK[32*i +: 32]) == BASE[32*i +: 32]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] addrFor(input int kind);
    logic [31:0] r;
    r = $urandom;
    case (kind)
      0:       return {r[31:16], 8'h20, r[7:0]};
      1:       return {r[31:16], 4'h1, r[11:0]};
      2:       return {r[31:16], 4'h2, 4'($urandom_range(1, 15)), r[7:0]};
      3:       return {r[31:16], 4'h3, r[11:0]};
      default: return {r[31:16], 4'($urandom_range(4, 15)), r[11:0]};
    endcase
  endfunction

  function automatic logic [NS*32-1:0] randData();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic [NS-1:0] gnt,
                               input logic [NS-1:0] rv, input logic [NS-1:0] err,
                               input logic [NS*32-1:0] rdata);
    m_req    = req;
    m_addr   = addr;
    m_we     = 1'($urandom);
    m_be     = 4'($urandom);
    m_wdata  = $urandom;
    s_gnt    = gnt;
    s_rvalid = rv;
    s_err    = err;
    s_rdata  = rdata;
    lastRv   = rv;
  endtask

  // Samples one cycle at the falling edge, then advances past the next rising edge.
  task automatic expectCycle(input string tag, input logic [NS-1:0] sreq, input logic gnt,
                             input logic rv, input logic err, input logic [31:0] rdata);
    @(negedge clk);
    checkOutput({tag, ".s_req"}, 32'(s_req), 32'(sreq));
    checkOutput({tag, ".m_gnt"}, 32'(m_gnt), 32'(gnt));
    checkOutput({tag, ".m_rvalid"}, 32'(m_rvalid), 32'(rv));
    checkOutput({tag, ".m_err"}, 32'(m_err), 32'(err));
    if (rv) checkOutput({tag, ".m_rdata"}, m_rdata, rdata);
    checkOutput({tag, ".s_addr"}, s_addr, m_addr);
    checkOutput({tag, ".s_wdata"}, s_wdata, m_wdata);
    @(posedge clk);
    #1;
    if (rst_n) staleRef = staleRef & ~lastRv;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, $urandom, '0, '0, '0, randData());
    expectCycle("idle", '0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // One master transaction. rspDelay = wait cycle carrying the slave response;
  // beyond TO the slave stays silent and the error response is expected instead.
  task automatic runTxn(input logic [31:0] addr, input int gntDelay, input int rspDelay,
                        input logic [31:0] data, input logic serr);
    int            k;
    logic [NS-1:0] kMask;
    logic [NS-1:0] noise;
    logic [NS*32-1:0] rd;
    k = refDecode(addr);
    if (k < 0) begin
      applyStimulus(1'b1, addr, 4'($urandom), '0, '0, randData());
      expectCycle("miss.req", '0, 1'b1, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, addrFor($urandom_range(0, 3)), '1, '0, '0, randData());
      expectCycle("miss.rsp", '0, 1'b0, 1'b1, 1'b1, 32'h0);
      return;
    end
    kMask = NS'(1) << k;
    if (staleRef[k]) begin
      applyStimulus(1'b1, addr, '1, '0, '0, randData());
      expectCycle("stale.hold", '0, 1'b0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, addr, '1, kMask, '0, randData());
      expectCycle("stale.drop", '0, 1'b0, 1'b0, 1'b0, 32'h0);
    end
    for (int c = 0; c <= gntDelay; c++) begin
      applyStimulus(1'b1, addr, ((c == gntDelay) ? kMask : '0) | (4'($urandom) & ~kMask),
                    '0, '0, randData());
      expectCycle("req", kMask, (c == gntDelay), 1'b0, 1'b0, 32'h0);
    end
    for (int w = 1; w <= TO; w++) begin
      noise = ($urandom_range(0, 3) == 0) ? (4'($urandom) & ~kMask) : '0;
      rd = randData();
      if (w == rspDelay) begin
        rd[32*k +: 32] = data;
        applyStimulus(1'b0, addr, '0, noise | kMask, (serr ? kMask : '0) | (4'($urandom) & ~kMask), rd);
        expectCycle("rsp", '0, 1'b0, 1'b1, serr, data);
        return;
      end
      applyStimulus(1'b0, addr, '0, noise, 4'($urandom) & ~kMask, rd);
      expectCycle("wait", '0, 1'b0, 1'b0, 1'b0, 32'h0);
    end
    applyStimulus(1'b0, addr, '0, '0, '0, randData());
    expectCycle("timeout", '0, 1'b0, 1'b1, 1'b1, 32'h0);
    staleRef[k] = 1'b1;
  endtask

  initial begin
    logic [NS*32-1:0] rd;
    int kind;
    int gd;
    int rdl;

    // Reset state.
    rst_n = 1'b0;
    applyStimulus(1'b1, 32'h0000_1004, '1, '0, '0, randData());
    expectCycle("reset", '0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, '0, '0, '0, randData());
    expectCycle("reset2", '0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    idleCycle();

    // Read to slave 1, then overlapping maps (0x2000 hits slaves 0 and 2), then unmapped.
    runTxn(32'h0000_1004, 0, 1, 32'hDEAD_BEEF, 1'b0);
    runTxn(32'h0000_2000, 1, 2, 32'h0BAD_F00D, 1'b0);
    runTxn(32'h0000_2104, 0, 3, 32'h2222_2222, 1'b1);
    runTxn(32'hF000_0000, 0, 1, 32'h0, 1'b0);
    runTxn(32'h0000_3000, 2, TO, 32'h3333_3333, 1'b0);

    // Back-to-back: hold while outstanding, then zero-bubble grants on rvalid.
    applyStimulus(1'b1, 32'h0000_1004, 4'b0010, '0, '0, randData());
    expectCycle("b2b.a", 4'b0010, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h0000_2004, 4'b1111, '0, '0, randData());
    expectCycle("b2b.hold", '0, 1'b0, 1'b0, 1'b0, 32'h0);
    rd = randData();
    rd[63:32] = 32'hDEAD_BEEF;
    applyStimulus(1'b1, 32'h0000_2004, 4'b0001, 4'b0010, '0, rd);
    expectCycle("b2b.ab", 4'b0001, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
    rd = randData();
    rd[31:0] = 32'h1234_5678;
    applyStimulus(1'b1, 32'hF000_0000, '0, 4'b0001, '0, rd);
    expectCycle("b2b.miss", '0, 1'b1, 1'b1, 1'b0, 32'h1234_5678);
    applyStimulus(1'b0, 32'h0, '0, '0, '0, randData());
    expectCycle("b2b.err", '0, 1'b0, 1'b1, 1'b1, 32'h0);

    // Slave 3 never answers: error after TO silent wait cycles, then held until the late rvalid.
    runTxn(32'h0000_3040, 0, TO + 1, 32'h0, 1'b0);
    for (int cy = TO + 2; cy < 20; cy++) begin
      applyStimulus(1'b1, 32'h0000_3040, '1, '0, '0, randData());
      expectCycle("to.hold", '0, 1'b0, 1'b0, 1'b0, 32'h0);
    end
    applyStimulus(1'b1, 32'h0000_3040, '1, 4'b1000, '0, randData());
    expectCycle("to.late", '0, 1'b0, 1'b0, 1'b0, 32'h0);
    runTxn(32'h0000_3040, 0, 1, 32'h4444_4444, 1'b0);

    // Reset while waiting for a response; the late response must not surface.
    applyStimulus(1'b1, 32'h0000_2104, 4'b0100, '0, '0, randData());
    expectCycle("rst.req", 4'b0100, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, '0, '0, '0, randData());
    expectCycle("rst.wait", '0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, '0, '0, '0, randData());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    staleRef = '0;
    applyStimulus(1'b0, 32'h0, '0, 4'b0100, '0, randData());
    expectCycle("rst.ignore", '0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Randomized traffic against the transaction model.
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 4);
      gd   = $urandom_range(0, 2);
      rdl  = (kind == 3 && $urandom_range(0, 2) == 0) ? TO + 1 : $urandom_range(1, TO);
      runTxn(addrFor(kind), gd, rdl, $urandom, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 1) == 0) idleCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
